// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults and drain state encoding for the FIFO drain
//                controller and its output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 128;
   localparam int LEN_W_DEF      = 9;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_GAP   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_out_buf
//  Description : Two-entry in-order output buffer with valid/ready read side.
//                Exposes its occupancy so the producer can reserve a slot
//                before issuing a read.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_out_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
)
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  valid,
   input  logic                  ready,
   output logic [DATA_WIDTH-1:0] data,
   output logic [1:0]            count
);

   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            occ;
   logic                  push;
   logic                  pop;

   assign pop   = valid && ready;
   // A full buffer can still accept a word in the same cycle one leaves.
   assign push  = wr_en && ((occ != 2'd2) || pop);
   assign valid = (occ != 2'd0);
   assign data  = mem[rd_ptr];
   assign count = occ;

   // Storage, pointers and occupancy; push+pop in one cycle keeps occupancy.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain_ctrl
//  Description : Drains a requested number of words from an upstream FIFO
//                (registered empty flag, one-cycle read latency) into a
//                valid/ready output stream, flagging the final word and
//                pulsing done at burst completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LEN_W      = LEN_W_DEF
)
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_start,
   input  logic [LEN_W-1:0]      i_len,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_rden,
   input  logic                  i_empty,
   input  logic [DATA_WIDTH-1:0] i_rddata,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last
);

   drain_state_t     state;
   logic [LEN_W-1:0] rd_cnt;
   logic [LEN_W-1:0] beat_cnt;
   logic             rd_pending;
   logic [1:0]       occ;
   logic             slot_free;
   logic             xfer;

   // A word already requested but not yet captured still needs a slot.
   assign slot_free = (({1'b0, occ} + {2'b00, rd_pending}) < 3'd2);

   // The read strobe must react to the current empty flag, so it is decoded
   // from the registered state rather than registered itself.
   assign o_rden = (state == S_READ) && !i_empty && slot_free;
   assign xfer   = o_valid && i_ready;
   assign o_last = o_valid && (beat_cnt == LEN_W'(1));
   // Busy covers the accepting cycle as well as every non-idle state.
   assign o_busy = (state != S_IDLE) || (rstn && i_start);

   // Burst sequencing, read/beat counters and the done pulse.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_IDLE;
         rd_cnt     <= '0;
         beat_cnt   <= '0;
         rd_pending <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_done     <= 1'b0;
         rd_pending <= o_rden;
         if (o_rden && (rd_cnt != '0)) begin
            rd_cnt <= rd_cnt - LEN_W'(1);
         end
         if (xfer && (beat_cnt != '0)) begin
            beat_cnt <= beat_cnt - LEN_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_len != '0) begin
                     state    <= S_READ;
                     rd_cnt   <= i_len;
                     beat_cnt <= i_len;
                  end else begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                  end
               end
            end
            S_READ: begin
               if (o_rden) begin
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               state <= (rd_cnt != '0) ? S_READ : S_DRAIN;
            end
            S_DRAIN: begin
               if ((xfer && (beat_cnt == LEN_W'(1))) || (beat_cnt == '0)) begin
                  state  <= S_DONE;
                  o_done <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   fifo_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (rd_pending),
      .wr_data (i_rddata),
      .valid   (o_valid),
      .ready   (i_ready),
      .data    (o_data),
      .count   (occ)
   );

endmodule
`default_nettype wire
